pipe_ctrl: RTL

Pipeline hazard controller. It generates the per-stage `ctrl` codes (`GO`/`STALL`/`FLUSH` from constants.vh) that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It resolves four hazard classes: load-use, multi-cycle EX operations, data-memory wait and control redirects. It is the producing end of the stage-register `ctrl` interface and sits beside the datapath in the pipeline top level.

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Stage-register control bus between the hazard controller and the datapath.
// master = pipe_ctrl (produces ctrl codes), slave = datapath (supplies hazard info).
interface pipe_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_usesRs1;
   logic       id_usesRs2;
   logic       ex_valid;
   logic       ex_memRd;
   logic       ex_regWr;
   logic [4:0] ex_rd;
   logic       mc_start;
   logic       mc_fp;
   logic       mem_redirect;
   logic       dmem_stall;
   logic       pc_en;
   logic [1:0] if_id_ctrl;
   logic [1:0] id_ex_ctrl;
   logic [1:0] ex_mem_ctrl;
   logic [1:0] mem_wb_ctrl;
   logic       mc_busy;

   modport master (
      input  id_rs1, id_rs2, id_usesRs1, id_usesRs2,
      input  ex_valid, ex_memRd, ex_regWr, ex_rd,
      input  mc_start, mc_fp, mem_redirect, dmem_stall,
      output pc_en, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, mc_busy
   );

   modport slave (
      output id_rs1, id_rs2, id_usesRs1, id_usesRs2,
      output ex_valid, ex_memRd, ex_regWr, ex_rd,
      output mc_start, mc_fp, mem_redirect, dmem_stall,
      input  pc_en, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, mc_busy
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle EX, dmem wait and redirect.
// Multi-cycle EX stalling is built only when PIPE_MC_STALL_EN is defined.
module pipe_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int FP_LAT  = 6,
   parameter int LAT_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.master bus
);
   // Stage-register ctrl encodings shared with the datapath.
   localparam logic [1:0] GO    = 2'b00;
   localparam logic [1:0] STALL = 2'b01;
   localparam logic [1:0] FLUSH = 2'b10;

   localparam logic MUL_MC = (MUL_LAT > 1);
   localparam logic FP_MC  = (FP_LAT > 1);
   localparam int   MUL_LDI = MUL_MC ? MUL_LAT - 2 : 0;
   localparam int   FP_LDI  = FP_MC  ? FP_LAT - 2  : 0;
   localparam logic [LAT_W-1:0] MUL_LD = MUL_LDI[LAT_W-1:0];
   localparam logic [LAT_W-1:0] FP_LD  = FP_LDI[LAT_W-1:0];

   logic       lu;
   logic       mc_stall;
   logic       in_wait;
   logic       pc_en;
   logic [1:0] if_id, id_ex, ex_mem, mem_wb;

   assign lu = bus.ex_valid && bus.ex_memRd && bus.ex_regWr && (bus.ex_rd != 5'd0) &&
               ((bus.id_usesRs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_usesRs2 && (bus.id_rs2 == bus.ex_rd)));

`ifdef PIPE_MC_STALL_EN
   typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             mc_long;
   logic             mc_go;

   assign mc_long  = bus.mc_fp ? FP_MC : MUL_MC;
   assign mc_go    = (state_q == RUN) && bus.mc_start && bus.ex_valid && mc_long;
   assign in_wait  = (state_q == MC_WAIT);
   assign mc_stall = (in_wait && (cnt_q != '0)) || mc_go;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.mem_redirect) begin
         // Redirect squashes the younger MC op sitting in EX.
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (mc_go) begin
                  state_d = MC_WAIT;
                  cnt_d   = bus.mc_fp ? FP_LD : MUL_LD;
               end
            end
            MC_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - LAT_W'(1);
               end else if (!bus.dmem_stall) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end
`else
   logic unused_mc;

   assign in_wait   = 1'b0;
   assign mc_stall  = 1'b0;
   assign unused_mc = ^{clk, bus.mc_start, bus.mc_fp, MUL_LD, FP_LD};
`endif

   always_comb begin
      pc_en  = 1'b1;
      if_id  = GO;
      id_ex  = GO;
      ex_mem = GO;
      mem_wb = GO;
      if (!rst) begin
         pc_en  = 1'b0;
         if_id  = FLUSH;
         id_ex  = FLUSH;
         ex_mem = FLUSH;
         mem_wb = FLUSH;
      end else if (bus.mem_redirect) begin
         if_id  = FLUSH;
         id_ex  = FLUSH;
         ex_mem = FLUSH;
      end else if (bus.dmem_stall) begin
         pc_en  = 1'b0;
         if_id  = STALL;
         id_ex  = STALL;
         ex_mem = STALL;
         mem_wb = FLUSH;
      end else if (mc_stall) begin
         pc_en  = 1'b0;
         if_id  = STALL;
         id_ex  = STALL;
         ex_mem = FLUSH;
      end else if (lu && !in_wait) begin
         // ID is already held while waiting on an MC op, so lu only matters in RUN.
         pc_en  = 1'b0;
         if_id  = STALL;
         id_ex  = FLUSH;
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.if_id_ctrl  = if_id;
   assign bus.id_ex_ctrl  = id_ex;
   assign bus.ex_mem_ctrl = ex_mem;
   assign bus.mem_wb_ctrl = mem_wb;
   assign bus.mc_busy     = rst && in_wait;
endmodule
